// File: rtl/nanorv32_rf_pkg.sv
// Shared definitions for the nanorv32 multi-port register file: size defaults,
// clear-sequencer state encoding and the flattened-bus slice helper.
package nanorv32_rf_pkg;

    localparam int unsigned RF_DATA_W_DEF   = 32;
    localparam int unsigned RF_NUM_REGS_DEF = 32;

    typedef enum logic {
        RF_ST_CLEAR = 1'b0,
        RF_ST_READY = 1'b1
    } rf_state_e;

    // Low bit of lane idx in a flattened bus of w-bit lanes.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/nanorv32_regfile_mp_if.sv
// Read/write port bundle of the nanorv32 register file; master is the core side,
// slave is the register file.
interface nanorv32_regfile_mp_if
    import nanorv32_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W_DEF,
    parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned AW       = $clog2(NUM_REGS)
);
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     wr_collision;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, wr_collision
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, wr_collision
    );
endinterface

// File: rtl/nanorv32_rf_clear_fsm.sv
// Clear sequencer: walks every register once after reset or on clear_req,
// then holds READY until the next clear request.
module nanorv32_rf_clear_fsm
    import nanorv32_rf_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          ready,
    output logic          clr_we_c,
    output logic [AW-1:0] clr_addr_c
);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ready_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_ST_CLEAR;
            ptr_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready   <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_d = ready;
        unique case (state_q)
            RF_ST_CLEAR: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = RF_ST_READY;
                    ptr_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            RF_ST_READY: begin
                if (clear_req) begin
                    state_d = RF_ST_CLEAR;
                    ptr_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = RF_ST_CLEAR;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign clr_we_c   = (state_q == RF_ST_CLEAR);
    assign clr_addr_c = ptr_q;

endmodule

// File: rtl/nanorv32_regfile_mp.sv
// nanorv32 multi-port register file with clear sequencer, fixed write priority
// and collision flag. Same-cycle write-to-read bypass when NANORV32_RF_BYPASS_EN is defined.
module nanorv32_regfile_mp
    import nanorv32_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W_DEF,
    parameter int unsigned NUM_REGS = RF_NUM_REGS_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic                  allow_hidden_use_of_x0,
    nanorv32_regfile_mp_if.slave  bus
);
    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [AW-1:0]            wa [NUM_WR];
    logic [DATA_W-1:0]        wd [NUM_WR];
    logic [AW-1:0]            ra [NUM_RD];
    logic [NUM_WR-1:0]        wr_ok_c;
    logic                     coll_c;
    logic                     wr_collision_q;
    logic                     clr_we_c;
    logic [AW-1:0]            clr_addr_c;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;

    // x0 is only visible in micro-ROM mode; addresses past the file are dead.
    function automatic logic addr_ok(input logic [AW-1:0] a, input logic x0_en);
        return ({1'b0, a} < (AW+1)'(NUM_REGS)) && ((a != '0) || x0_en);
    endfunction

    nanorv32_rf_clear_fsm #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .ready      (ready),
        .clr_we_c   (clr_we_c),
        .clr_addr_c (clr_addr_c)
    );

    for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_unpack
        assign wa[g] = bus.wr_addr[slice_lo(g, AW) +: AW];
        assign wd[g] = bus.wr_data[slice_lo(g, DATA_W) +: DATA_W];
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_unpack
        assign ra[g] = bus.rd_addr[slice_lo(g, AW) +: AW];
    end

    // A write lands only in READY with no clear pending and a legal address.
    always_comb begin
        wr_ok_c = '0;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            wr_ok_c[p] = ready && !clear_req && bus.wr_en[p] &&
                         addr_ok(wa[p], allow_hidden_use_of_x0);
        end
    end

    always_comb begin
        coll_c = 1'b0;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            for (int q = p + 1; q < int'(NUM_WR); q++) begin
                if (wr_ok_c[p] && wr_ok_c[q] && (wa[p] == wa[q])) begin
                    coll_c = 1'b1;
                end
            end
        end
    end

    // Ports applied high-to-low so the lowest index lands last and wins.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            regs[clr_addr_c] <= '0;
        end else begin
            for (int p = int'(NUM_WR) - 1; p >= 0; p--) begin
                if (wr_ok_c[p]) begin
                    regs[wa[p]] <= wd[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_collision_q <= 1'b0;
        end else begin
            wr_collision_q <= coll_c;
        end
    end

    always_comb begin
        rd_data_c = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            if (ready && addr_ok(ra[k], allow_hidden_use_of_x0)) begin
                rd_data_c[slice_lo(k, DATA_W) +: DATA_W] = regs[ra[k]];
`ifdef NANORV32_RF_BYPASS_EN
                for (int p = int'(NUM_WR) - 1; p >= 0; p--) begin
                    if (wr_ok_c[p] && (wa[p] == ra[k])) begin
                        rd_data_c[slice_lo(k, DATA_W) +: DATA_W] = wd[p];
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.wr_collision = wr_collision_q;

endmodule

// File: tb/tb_nanorv32_regfile_mp.sv
// Directed bench for nanorv32_regfile_mp (default 32x32, 2R/2W): vector table
// for single-write scenarios plus hand sequences for clear, reset and same-cycle reads.
module tb_nanorv32_regfile_mp;

`ifdef NANORV32_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear_req = 1'b0;
    logic ready;
    logic x0 = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    nanorv32_regfile_mp_if bus_if ();

    nanorv32_regfile_mp dut (
        .clk                    (clk),
        .rst                    (rst),
        .clear_req              (clear_req),
        .ready                  (ready),
        .allow_hidden_use_of_x0 (x0),
        .bus                    (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        x0;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ec;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
        bus_if.wr_en   = we;
        bus_if.wr_addr = {a1, a0};
        bus_if.wr_data = {d1, d0};
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus_if.rd_addr = {a1, a0};
    endtask

    // Expects ready low for 31 edges and high after the 32nd; reads stay 0 meanwhile.
    task automatic count_clear(input string nm);
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk($sformatf("%s_ready_e%0d", nm, i), 32'(ready), 32'(i == 32));
            if (i < 32) begin
                chk($sformatf("%s_rd_e%0d", nm, i), bus_if.rd_data[31:0] | bus_if.rd_data[63:32], 32'h0);
            end
        end
    endtask

    initial begin
        vt[0] = '{1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0};
        vt[1] = '{1'b0, 2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0, 5'd0, 5'd0, 32'h12345678, 32'h12345678, 1'b0};
        vt[3] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0};
        vt[4] = '{1'b0, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 5'd7, 5'd7, 32'h11111111, 32'h11111111, 1'b1};
        vt[5] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5, 32'h11111111, 32'hDEADBEEF, 1'b0};
        vt[6] = '{1'b0, 2'b11, 5'd8, 32'hAAAA0008, 5'd9, 32'hBBBB0009, 5'd8, 5'd9, 32'hAAAA0008, 32'hBBBB0009, 1'b0};
        vt[7] = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd31, 32'h31313131, 5'd31, 5'd9, 32'h31313131, 32'hBBBB0009, 1'b0};
        vt[8] = '{1'b0, 2'b11, 5'd0, 32'h0F0F0F0F, 5'd0, 32'hF0F0F0F0, 5'd0, 5'd8, 32'h0, 32'hAAAA0008, 1'b0};
        vt[9] = '{1'b1, 2'b11, 5'd0, 32'h000000A0, 5'd0, 32'h000000A1, 5'd0, 5'd0, 32'h000000A0, 32'h000000A0, 1'b1};

        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd31);

        // Reset state
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_coll", 32'(bus_if.wr_collision), 32'h0);
        chk("rst_rd", bus_if.rd_data[31:0] | bus_if.rd_data[63:32], 32'h0);
        rst = 1'b0;
        count_clear("init");

        // Table: write on one edge, read back and check collision after it
        for (int v = 0; v < 10; v++) begin
            x0 = vt[v].x0;
            set_wr(vt[v].we, vt[v].wa0, vt[v].wd0, vt[v].wa1, vt[v].wd1);
            tick();
            set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            set_rd(vt[v].ra0, vt[v].ra1);
            #1;
            chk($sformatf("vec%0d_rd0", v), bus_if.rd_data[31:0], vt[v].e0);
            chk($sformatf("vec%0d_rd1", v), bus_if.rd_data[63:32], vt[v].e1);
            chk($sformatf("vec%0d_coll", v), 32'(bus_if.wr_collision), 32'(vt[v].ec));
        end
        x0 = 1'b0;
        tick();
        chk("coll_drop", 32'(bus_if.wr_collision), 32'h0);

        // clear_req with writes in the same cycle; writes and mid-clear requests ignored
        clear_req = 1'b1;
        set_wr(2'b11, 5'd5, 32'h55555555, 5'd10, 32'hAAAAAAAA);
        tick();
        clear_req = 1'b0;
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("clr_ready_low", 32'(ready), 32'h0);
        for (int i = 1; i <= 32; i++) begin
            clear_req = (i == 5);
            if (i == 3) set_wr(2'b01, 5'd12, 32'hFFFF0012, 5'd0, 32'h0);
            else        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
            tick();
            chk($sformatf("clr_ready_e%0d", i), 32'(ready), 32'(i == 32));
        end
        clear_req = 1'b0;
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd10);
        #1;
        chk("clr_r5", bus_if.rd_data[31:0], 32'h0);
        chk("clr_r10", bus_if.rd_data[63:32], 32'h0);
        set_rd(5'd7, 5'd12);
        #1;
        chk("clr_r7", bus_if.rd_data[31:0], 32'h0);
        chk("clr_r12", bus_if.rd_data[63:32], 32'h0);
        x0 = 1'b1;
        set_rd(5'd0, 5'd31);
        #1;
        chk("clr_r0", bus_if.rd_data[31:0], 32'h0);
        chk("clr_r31", bus_if.rd_data[63:32], 32'h0);
        x0 = 1'b0;

        // Reset asserted at clr_ptr=10 restarts the full clear
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        chk("mid_ready_low", 32'(ready), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'h0);
        tick();
        tick();
        chk("mid_rst_hold", 32'(ready), 32'h0);
        rst = 1'b0;
        count_clear("rerun");

        // Same-cycle write/read: bypass vs. stored value
        set_wr(2'b01, 5'd3, 32'h0BAD0003, 5'd0, 32'h0);
        tick();
        set_wr(2'b11, 5'd3, 32'hCAFEF00D, 5'd0, 32'h77777777);
        set_rd(5'd0, 5'd3);
        #1;
        chk("byp_rd1", bus_if.rd_data[63:32], BYP ? 32'hCAFEF00D : 32'h0BAD0003);
        chk("byp_x0", bus_if.rd_data[31:0], 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("byp_after", bus_if.rd_data[63:32], 32'hCAFEF00D);
        chk("byp_coll0", 32'(bus_if.wr_collision), 32'h0);
        set_wr(2'b11, 5'd4, 32'h44444444, 5'd4, 32'h55555555);
        set_rd(5'd4, 5'd4);
        #1;
        chk("byp_prio", bus_if.rd_data[31:0], BYP ? 32'h44444444 : 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1;
        chk("prio_store", bus_if.rd_data[63:32], 32'h44444444);
        chk("prio_coll", 32'(bus_if.wr_collision), 32'h1);
        tick();
        chk("prio_coll_end", 32'(bus_if.wr_collision), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
